// File: rtl/cr16_mem_port_if.sv
// Bundle of the request-side and memory-side signals of the CR16 memory port.
// The environment (CPU control plus memory model) uses master; the port unit uses slave.
interface cr16_mem_port_if #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 16
);
    // Handshakes: start is a one-cycle request accepted only while busy=0; once
    // mem_req is high it stays high with mem_adr/mem_we/mem_wdata stable until the
    // edge that samples mem_ack=1 (or the wait budget runs out); done pulses once
    // per accepted request, with err qualified by done.
    logic              start;
    logic [1:0]        op;
    logic [AWIDTH-1:0] addr_in;
    logic [DWIDTH-1:0] wdata_in;
    logic              mem_ack;
    logic [DWIDTH-1:0] mem_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_adr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [AWIDTH-1:0] mar_out;
    logic [DWIDTH-1:0] mdr_out;
    logic [DWIDTH-1:0] ir_out;
    logic [DWIDTH-1:0] imm_ext;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        fsm_state;

    modport master (
        output start, op, addr_in, wdata_in, mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_adr, mem_wdata, mar_out, mdr_out, ir_out,
               imm_ext, busy, done, err, fsm_state
    );

    modport slave (
        input  start, op, addr_in, wdata_in, mem_ack, mem_rdata,
        output mem_req, mem_we, mem_adr, mem_wdata, mar_out, mdr_out, ir_out,
               imm_ext, busy, done, err, fsm_state
    );
endinterface

// File: rtl/cr16_mem_port.sv
// Multicycle memory-access unit: owns MAR/MDR/IR and sequences fetch, load and
// store over a req/ack bus with a bounded wait-state budget.
module cr16_mem_port #(
    parameter int AWIDTH  = 16,
    parameter int DWIDTH  = 16,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 5
) (
    input logic            clk,
    input logic            reset,
    cr16_mem_port_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    state_t            state;
    logic [AWIDTH-1:0] mar;
    logic [DWIDTH-1:0] mdr;
    logic [DWIDTH-1:0] ir;
    logic [CNTW-1:0]   cnt;
    logic [1:0]        op_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mar       <= '0;
            mdr       <= '0;
            ir        <= '0;
            cnt       <= '0;
            op_q      <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.op == OP_RSVD) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state     <= S_ISSUE;
                            mar       <= bus.addr_in;
                            op_q      <= bus.op;
                            cnt       <= '0;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= (bus.op == OP_STORE);
                            if (bus.op == OP_STORE) mdr <= bus.wdata_in;
                        end
                    end
                end
                S_ISSUE: begin
                    // Ack wins over the timeout when both land on the same edge.
                    if (bus.mem_ack) begin
                        if (op_q == OP_FETCH) ir  <= bus.mem_rdata;
                        if (op_q == OP_LOAD)  mdr <= bus.mem_rdata;
                        state     <= S_DONE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                        if (cnt == CNT_LAST) begin
                            state     <= S_DONE;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_adr   = mar;
    assign bus.mem_wdata = mdr;
    assign bus.mar_out   = mar;
    assign bus.mdr_out   = mdr;
    assign bus.ir_out    = ir;
    assign bus.imm_ext   = {{(DWIDTH-8){ir[7]}}, ir[7:0]};
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_cr16_mem_port.sv
// Self-checking bench for cr16_mem_port: directed test-plan accesses, a few
// random ones, and a scoreboard of expected completion state popped on done.
module tb_cr16_mem_port;
    localparam int AWIDTH  = 16;
    localparam int DWIDTH  = 16;
    localparam int TIMEOUT = 16;
    localparam int CNTW    = 5;
    localparam int EW      = 1 + AWIDTH + 2*DWIDTH;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [EW-1:0]     exp_q[$];
    logic [AWIDTH-1:0] m_mar;
    logic [DWIDTH-1:0] m_mdr;
    logic [DWIDTH-1:0] m_ir;

    cr16_mem_port_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus();

    cr16_mem_port #(
        .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_err", bus.err,     e[EW-1]);
                check("done_mar", bus.mar_out, e[AWIDTH+2*DWIDTH-1 -: AWIDTH]);
                check("done_mdr", bus.mdr_out, e[2*DWIDTH-1 -: DWIDTH]);
                check("done_ir",  bus.ir_out,  e[DWIDTH-1:0]);
            end
        end else begin
            check("err_without_done", bus.err, 0);
        end
    end

    // ---------------- driver ----------------
    // waits < 0 means the memory never acknowledges.
    task automatic run_access(input logic [1:0] op, input logic [15:0] addr,
                              input logic [15:0] wdata, input int waits,
                              input logic [15:0] rdata, input int glitch_cyc,
                              input bit start_on_done);
        int  cyc;
        int  nreq;
        int  exp_lat;
        int  exp_req;
        bit  seen;
        bit  exp_err;
        bit  acks;
        acks = (waits >= 0) && (waits < TIMEOUT);
        if (op == 2'b11) begin
            exp_err = 1'b1; exp_lat = 1; exp_req = 0;
        end else begin
            m_mar = addr;
            if (op == 2'b10) m_mdr = wdata;
            if (acks) begin
                exp_err = 1'b0; exp_lat = waits + 2; exp_req = waits + 1;
                if (op == 2'b00) m_ir  = rdata;
                if (op == 2'b01) m_mdr = rdata;
            end else begin
                exp_err = 1'b1; exp_lat = TIMEOUT + 1; exp_req = TIMEOUT;
            end
        end

        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.addr_in  = addr;
        bus.wdata_in = wdata;
        bus.mem_ack  = 1'b0;
        exp_q.push_back({exp_err, m_mar, m_mdr, m_ir});

        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1; nreq = 0; seen = 1'b0;
        while (!seen && cyc <= 60) begin
            if (bus.done) begin
                seen = 1'b1;
                check("latency", cyc, exp_lat);
                check("req_cycles", nreq, exp_req);
                bus.mem_ack = 1'b0;
                if (start_on_done) begin
                    bus.start   = 1'b1;
                    bus.op      = 2'b00;
                    bus.addr_in = 16'h7777;
                end
            end else begin
                if (bus.mem_req) begin
                    nreq++;
                    check("mem_adr", bus.mem_adr, addr);
                    check("mem_we", bus.mem_we, (op == 2'b10));
                    if (op == 2'b10) check("mem_wdata", bus.mem_wdata, wdata);
                    bus.mem_ack   = acks && (nreq == waits + 1);
                    bus.mem_rdata = bus.mem_ack ? rdata : 16'($urandom_range(0, 16'hFFFF));
                end else begin
                    bus.mem_ack = 1'b0;
                end
                if (glitch_cyc != 0 && cyc == glitch_cyc) begin
                    bus.start   = 1'b1;
                    bus.op      = 2'b01;
                    bus.addr_in = 16'hDEAD;
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) check("done_seen", 0, 1);
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_busy", bus.busy, 0);
        check("idle_req", bus.mem_req, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0; n_fail = 0;
        m_mar = '0; m_mdr = '0; m_ir = '0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.addr_in = '0; bus.wdata_in = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req",   bus.mem_req, 0);
        check("rst_we",    bus.mem_we, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_mar",   bus.mar_out, 0);
        check("rst_mdr",   bus.mdr_out, 0);
        check("rst_ir",    bus.ir_out, 0);
        check("rst_state", bus.fsm_state, 0);
        reset = 1'b0;

        run_access(2'b00, 16'h0040, 16'h0000, 0, 16'h5A85, 0, 0);
        check("fetch_ir", bus.ir_out, 16'h5A85);
        check("imm_ext_neg", bus.imm_ext, 16'hFF85);

        run_access(2'b01, 16'h1234, 16'h0000, 3, 16'hBEEF, 0, 0);
        check("load_mdr", bus.mdr_out, 16'hBEEF);
        check("load_ir_kept", bus.ir_out, 16'h5A85);

        run_access(2'b10, 16'h00FF, 16'hCAFE, 1, 16'h0000, 0, 0);
        check("store_mdr", bus.mdr_out, 16'hCAFE);

        run_access(2'b00, 16'h0100, 16'h0000, -1, 16'h1111, 0, 0);
        check("timeout_ir_kept", bus.ir_out, 16'h5A85);

        run_access(2'b00, 16'h0102, 16'h0000, TIMEOUT - 1, 16'h1357, 0, 0);
        check("late_ack_ir", bus.ir_out, 16'h1357);
        check("imm_ext_pos", bus.imm_ext, 16'h0057);

        run_access(2'b11, 16'h0200, 16'h0000, 0, 16'h0000, 0, 0);
        check("rsvd_mar_kept", bus.mar_out, 16'h0102);

        run_access(2'b01, 16'h0300, 16'h0000, 3, 16'h2468, 2, 0);
        check("glitch_mar", bus.mar_out, 16'h0300);

        run_access(2'b00, 16'h0400, 16'h0000, 0, 16'h0F0F, 0, 1);

        for (int i = 0; i < 6; i++) begin
            run_access(2'($urandom_range(0, 2)), 16'($urandom_range(0, 16'hFFFF)),
                       16'($urandom_range(0, 16'hFFFF)), $urandom_range(0, 4),
                       16'($urandom_range(0, 16'hFFFF)), 0, 0);
        end

        // Reset in the second wait cycle of a load.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.addr_in = 16'h2000; bus.mem_ack = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("rst_mid_req1", bus.mem_req, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_mar = '0; m_mdr = '0; m_ir = '0;
        check("rst_mid_req", bus.mem_req, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_mar", bus.mar_out, 0);
        check("rst_mid_mdr", bus.mdr_out, 0);
        check("rst_mid_ir", bus.ir_out, 0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'hFFFF;
        repeat (4) @(negedge clk);
        bus.mem_ack = 1'b0;
        check("rst_ack_ignored", bus.mdr_out, 0);
        check("rst_ack_busy", bus.busy, 0);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
